// File: rtl/nx_node_router_pkg.sv
// rtl/nx_node_router_pkg.sv - message types, router constants, route decode and round-robin pick
package nx_node_router_pkg;

    localparam int ADDR_ROW_WIDTH    = 4;
    localparam int ADDR_COL_WIDTH    = 4;
    localparam int PAYLOAD_WIDTH     = 24;
    localparam int NX_ROUTER_SOURCES = 5;
    localparam int NX_ROUTER_DESTS   = 5;

    typedef struct packed {
        logic [ADDR_ROW_WIDTH-1:0] row;
        logic [ADDR_COL_WIDTH-1:0] column;
    } node_header_t;

    typedef struct packed {
        node_header_t             header;
        logic [PAYLOAD_WIDTH-1:0] payload;
    } node_message_t;

    // Encoding doubles as the destination index: 0..3 = ob port N,E,S,W, 4 = internal.
    typedef enum logic [2:0] {
        RT_NORTH    = 3'd0,
        RT_EAST     = 3'd1,
        RT_SOUTH    = 3'd2,
        RT_WEST     = 3'd3,
        RT_INTERNAL = 3'd4
    } router_target_t;

    // Dimension-order routing: resolve the row first, then the column.
    function automatic router_target_t route_of(input node_header_t header,
                                                input logic [ADDR_ROW_WIDTH-1:0] row,
                                                input logic [ADDR_COL_WIDTH-1:0] col);
        router_target_t t;
        if (header.row < row)         t = RT_NORTH;
        else if (header.row > row)    t = RT_SOUTH;
        else if (header.column < col) t = RT_WEST;
        else if (header.column > col) t = RT_EAST;
        else                          t = RT_INTERNAL;
        return t;
    endfunction

    // First requester at or after ptr, modulo 5. Returns {found, index}.
    function automatic logic [3:0] rr_pick(input logic [4:0] req, input logic [2:0] ptr);
        logic [3:0] r;
        int         idx;
        r = 4'd0;
        for (int k = 0; k < NX_ROUTER_SOURCES; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NX_ROUTER_SOURCES) idx = idx - NX_ROUTER_SOURCES;
            if (!r[3] && req[idx]) r = {1'b1, 3'(idx)};
        end
        return r;
    endfunction

endpackage

// File: rtl/nx_router_fifo.sv
// rtl/nx_router_fifo.sv - inbound message FIFO with registered full/empty flags
// Ports: clk, rst (sync, active-high); push/push_data write side (refused when full);
//        pop/head read side (head valid while !empty); full, empty registered flags.
module nx_router_fifo
    import nx_node_router_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  node_message_t push_data,
    input  logic          pop,
    output node_message_t head,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    node_message_t mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          do_push;
    logic          do_pop;

    // Full is a registered flag, so a pop in the same cycle never frees room for a push.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (do_push && !do_pop)      count_next = count + CW'(1);
        else if (!do_push && do_pop) count_next = count - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/nx_node_router.sv
// rtl/nx_node_router.sv - five-source buffered mesh node router (N,E,S,W inbound + local emit)
// Ports: clk_i, rst_i (sync, active-high); node_row_i/node_col_i node address; idle_o;
//        ib_data_i/ib_valid_i/ib_ready_o inbound N,E,S,W; lcl_data_i/lcl_valid_i/lcl_ready_o local;
//        int_data_o/int_valid_o/int_ready_i to decoder; ob_data_o/ob_valid_o/ob_ready_i outbound;
//        ob_present_i neighbour presence. Macro NX_ROUTER_STATS_EN adds drop_count_o, fwd_count_o.
module nx_node_router
    import nx_node_router_pkg::*;
#(
    parameter int    FIFO_DEPTH = 2,
    parameter string ARB_SCHEME = "round_robin"
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [ADDR_ROW_WIDTH-1:0] node_row_i,
    input  logic [ADDR_COL_WIDTH-1:0] node_col_i,
    output logic                      idle_o,
    input  node_message_t [3:0]       ib_data_i,
    input  logic [3:0]                ib_valid_i,
    output logic [3:0]                ib_ready_o,
    input  node_message_t             lcl_data_i,
    input  logic                      lcl_valid_i,
    output logic                      lcl_ready_o,
    output node_message_t             int_data_o,
    output logic                      int_valid_o,
    input  logic                      int_ready_i,
    output node_message_t [3:0]       ob_data_o,
    output logic [3:0]                ob_valid_o,
    input  logic [3:0]                ob_ready_i,
    input  logic [3:0]                ob_present_i
`ifdef NX_ROUTER_STATS_EN
    ,
    output logic [15:0]               drop_count_o,
    output logic [3:0][15:0]          fwd_count_o
`endif
);

    localparam bit PREFER_LOCAL = (ARB_SCHEME == "prefer_local");

    node_message_t                 fifo_head [4];
    logic [3:0]                    fifo_full;
    logic [3:0]                    fifo_empty;

    node_message_t                 src_data [NX_ROUTER_SOURCES];
    router_target_t                src_tgt  [NX_ROUTER_SOURCES];
    logic [NX_ROUTER_SOURCES-1:0]  src_valid;
    logic [NX_ROUTER_SOURCES-1:0]  src_drop;
    logic [NX_ROUTER_SOURCES-1:0]  src_taken;

    logic [NX_ROUTER_SOURCES-1:0]  req [NX_ROUTER_DESTS];
    logic [2:0]                    ptr [NX_ROUTER_DESTS];
    logic [2:0]                    gnt_idx [NX_ROUTER_DESTS];
    logic [NX_ROUTER_DESTS-1:0]    gnt_any;
    logic [NX_ROUTER_DESTS-1:0]    dst_ready;
    logic [NX_ROUTER_DESTS-1:0]    dst_open;
    logic [NX_ROUTER_DESTS-1:0]    out_valid;
    node_message_t                 out_data [NX_ROUTER_DESTS];

    for (genvar i = 0; i < 4; i++) begin : g_fifo
        nx_router_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk       (clk_i),
            .rst       (rst_i),
            .push      (ib_valid_i[i]),
            .push_data (ib_data_i[i]),
            .pop       (src_taken[i]),
            .head      (fifo_head[i]),
            .full      (fifo_full[i]),
            .empty     (fifo_empty[i])
        );
    end

    assign ib_ready_o = ~fifo_full;

    // Source heads, their routes, and absent-neighbour drops (dropped heads never enter arbitration).
    always_comb begin
        for (int s = 0; s < 4; s++) begin
            src_valid[s] = !fifo_empty[s];
            src_data[s]  = fifo_head[s];
        end
        src_valid[4] = lcl_valid_i;
        src_data[4]  = lcl_data_i;
        for (int s = 0; s < NX_ROUTER_SOURCES; s++) begin
            src_tgt[s]  = route_of(src_data[s].header, node_row_i, node_col_i);
            src_drop[s] = src_valid[s] && (src_tgt[s] != RT_INTERNAL) &&
                          !ob_present_i[2'(src_tgt[s])];
        end
    end

    // One arbiter per destination; a destination only requests when its output register can load.
    always_comb begin
        dst_ready = {int_ready_i, ob_ready_i};
        dst_open  = ~out_valid | dst_ready;
        src_taken = src_drop;
        gnt_any   = '0;
        for (int d = 0; d < NX_ROUTER_DESTS; d++) begin
            gnt_idx[d] = 3'd0;
            for (int s = 0; s < NX_ROUTER_SOURCES; s++) begin
                req[d][s] = src_valid[s] && !src_drop[s] && dst_open[d] &&
                            (3'(src_tgt[s]) == 3'(d));
            end
            if (PREFER_LOCAL && req[d][4]) begin
                gnt_any[d] = 1'b1;
                gnt_idx[d] = 3'd4;
            end else begin
                {gnt_any[d], gnt_idx[d]} = rr_pick(req[d], ptr[d]);
            end
            if (gnt_any[d]) src_taken[gnt_idx[d]] = 1'b1;
        end
    end

    // Local stream has no buffer: ready is the grant (or drop) itself, held low in reset.
    assign lcl_ready_o = src_taken[4] && !rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int d = 0; d < NX_ROUTER_DESTS; d++) begin
                out_valid[d] <= 1'b0;
                out_data[d]  <= '0;
                ptr[d]       <= 3'd0;
            end
            idle_o <= 1'b0;
        end else begin
            for (int d = 0; d < NX_ROUTER_DESTS; d++) begin
                if (gnt_any[d]) begin
                    out_valid[d] <= 1'b1;
                    out_data[d]  <= src_data[gnt_idx[d]];
                    ptr[d]       <= (gnt_idx[d] == 3'd4) ? 3'd0 : gnt_idx[d] + 3'd1;
                end else if (dst_ready[d]) begin
                    out_valid[d] <= 1'b0;
                end
            end
            idle_o <= (&fifo_empty) && !(|out_valid) && !(|ib_valid_i) && !lcl_valid_i;
        end
    end

    always_comb begin
        for (int d = 0; d < 4; d++) ob_data_o[d] = out_data[d];
    end
    assign ob_valid_o  = out_valid[3:0];
    assign int_valid_o = out_valid[4];
    assign int_data_o  = out_data[4];

`ifdef NX_ROUTER_STATS_EN
    logic [2:0]  drop_num;
    logic [16:0] drop_sum;

    always_comb begin
        drop_num = '0;
        for (int s = 0; s < NX_ROUTER_SOURCES; s++) drop_num = drop_num + 3'(src_drop[s]);
        drop_sum = 17'(drop_count_o) + 17'(drop_num);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_count_o <= '0;
            fwd_count_o  <= '0;
        end else begin
            drop_count_o <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            for (int d = 0; d < 4; d++) begin
                if (ob_valid_o[d] && ob_ready_i[d] && (fwd_count_o[d] != 16'hFFFF))
                    fwd_count_o[d] <= fwd_count_o[d] + 16'd1;
            end
        end
    end
`endif

endmodule
